// File: rtl/mux_pkg.sv
// Shared types and the rotating first-one search used by the mux arbiter.
package mux_pkg;

  localparam int MAX_N = 16;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First set bit of req scanning start, start+1 .. start+n-1 (mod n).
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input logic [3:0]       start,
                                    input int               n);
    pick_t res;
    int    j;
    res = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        j = int'(start) + i;
        if (j >= n) j = j - n;
        if (!res.found && req[j]) begin
          res.found = 1'b1;
          res.idx   = 4'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/data/grant bundle between N sources and the shared-channel arbiter.
interface mux_rr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   gnt;
  logic [SW-1:0]  sel;
  logic [W-1:0]   y;
  logic           y_valid;

  modport master (output req, data_in, input gnt, sel, y, y_valid);
  modport slave  (input req, data_in, output gnt, sel, y, y_valid);
endinterface

// File: rtl/mux_nx1.sv
// Combinational N:1 word multiplexer; out-of-range selects yield zero.
module mux_nx1 #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic [N*W-1:0] data_i,
  input  logic [SW-1:0]  sel_i,
  output logic [W-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_i == SW'(k)) data_o = data_i[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared N:1 word mux, with a per-grant hold limit.
// y/y_valid trail gnt by one cycle; back-to-back grants insert no idle cycle.
module mux_rr_arbiter
  import mux_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.slave   bus
);

  localparam int SW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  state_e           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [W-1:0]     y_q;
  logic             y_valid_q;

  logic [W-1:0]     mux_out;
  logic [SW-1:0]    sel_nxt;
  logic             release_w;
  logic [MAX_N-1:0] req_ext;
  logic [MAX_N-1:0] cand;
  pick_t            pick;

  mux_nx1 #(.N(N), .W(W)) u_mux (
    .data_i (bus.data_in),
    .sel_i  (sel_q),
    .data_o (mux_out)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    pick      = '0;
    req_ext   = '0;
    req_ext[N-1:0] = bus.req;
    cand      = req_ext;
    sel_nxt   = (sel_q == SW'(N - 1)) ? '0 : sel_q + SW'(1);
    release_w = !bus.req[sel_q] || (hold_q == HW'(MAX_HOLD - 1));

    unique case (state_q)
      IDLE: begin
        pick = rr_pick(req_ext, 4'(ptr_q), N);
        if (pick.found) begin
          state_d = GRANT;
          sel_d   = SW'(pick.idx);
          gnt_d   = N'(1) << pick.idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!release_w) begin
          hold_d = hold_q + HW'(1);
        end else begin
          // The outgoing owner is masked so a waiting peer always wins the rescan.
          ptr_d        = sel_nxt;
          hold_d       = '0;
          cand[sel_q]  = 1'b0;
          pick         = rr_pick(cand, 4'(sel_nxt), N);
          if (pick.found) begin
            sel_d = SW'(pick.idx);
            gnt_d = N'(1) << pick.idx;
          end else if (!bus.req[sel_q]) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      y_valid_q <= (state_q == GRANT);
      if (state_q == GRANT) y_q <= mux_out;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed scoreboard bench: each vector carries the hand-derived state after its edge.
module tb_mux_rr_arbiter;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] y;
    logic       yv;
    int         ptr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   mon_idx = 0;

  mux_rr_arbiter_if #(.N(4), .W(8)) bus ();

  mux_rr_arbiter #(.N(4), .W(8), .MAX_HOLD(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, idx, act, want);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g, input logic [1:0] s,
                     input logic [7:0] y, input logic yv, input int p);
    vec_t v;
    v.rst_n = r; v.req = q; v.gnt = g; v.sel = s; v.y = y; v.yv = yv; v.ptr = p;
    vecs.push_back(v);
  endtask

  // Monitor: one edge's expectation is compared just after that edge.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt", mon_idx, 32'(bus.gnt), 32'(e.gnt));
        check("sel", mon_idx, 32'(bus.sel), 32'(e.sel));
        check("y", mon_idx, 32'(bus.y), 32'(e.y));
        check("y_valid", mon_idx, 32'(bus.y_valid), 32'(e.yv));
        check("gnt_onehot0", mon_idx, 32'($onehot0(bus.gnt)), 32'd1);
        if (e.ptr >= 0) check("ptr", mon_idx, 32'(dut.ptr_q), e.ptr);
        mon_idx++;
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    bus.req     = 4'b0000;
    bus.data_in = {8'h3C, 8'hA5, 8'h21, 8'h10};

    // reset with all requests high
    add(0, 4'hF, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'hF, 4'h0, 0, 8'h00, 0, 0);
    // full rotation, MAX_HOLD=3
    add(1, 4'hF, 4'h1, 0, 8'h00, 0, 0);
    add(1, 4'hF, 4'h1, 0, 8'h10, 1, -1);
    add(1, 4'hF, 4'h1, 0, 8'h10, 1, -1);
    add(1, 4'hF, 4'h2, 1, 8'h10, 1, 1);
    add(1, 4'hF, 4'h2, 1, 8'h21, 1, -1);
    add(1, 4'hF, 4'h2, 1, 8'h21, 1, -1);
    add(1, 4'hF, 4'h4, 2, 8'h21, 1, 2);
    add(1, 4'hF, 4'h4, 2, 8'hA5, 1, -1);
    add(1, 4'hF, 4'h4, 2, 8'hA5, 1, -1);
    add(1, 4'hF, 4'h8, 3, 8'hA5, 1, 3);
    add(1, 4'hF, 4'h8, 3, 8'h3C, 1, -1);
    add(1, 4'hF, 4'h8, 3, 8'h3C, 1, -1);
    add(1, 4'hF, 4'h1, 0, 8'h3C, 1, 0);
    add(1, 4'hF, 4'h1, 0, 8'h10, 1, -1);
    add(1, 4'h0, 4'h0, 0, 8'h10, 1, 1);
    add(1, 4'h0, 4'h0, 0, 8'h10, 0, 1);
    // single source 2, re-granted at hold expiry
    add(1, 4'h4, 4'h4, 2, 8'h10, 0, 1);
    add(1, 4'h4, 4'h4, 2, 8'hA5, 1, -1);
    add(1, 4'h4, 4'h4, 2, 8'hA5, 1, -1);
    add(1, 4'h4, 4'h4, 2, 8'hA5, 1, 3);
    add(1, 4'h4, 4'h4, 2, 8'hA5, 1, -1);
    add(1, 4'h0, 4'h0, 2, 8'hA5, 1, 3);
    add(1, 4'h0, 4'h0, 2, 8'hA5, 0, -1);
    // sole requester 1 for 10 cycles
    add(1, 4'h2, 4'h2, 1, 8'hA5, 0, 3);
    for (int i = 0; i < 9; i++) add(1, 4'h2, 4'h2, 1, 8'h21, 1, (i >= 2) ? 2 : 3);
    add(1, 4'h0, 4'h0, 1, 8'h21, 1, 2);
    // early release of src0 with src3 arriving the same cycle
    add(1, 4'h1, 4'h1, 0, 8'h21, 0, 2);
    add(1, 4'h1, 4'h1, 0, 8'h10, 1, -1);
    add(1, 4'h8, 4'h8, 3, 8'h10, 1, 1);
    add(1, 4'h8, 4'h8, 3, 8'h3C, 1, 1);
    add(1, 4'h0, 4'h0, 3, 8'h3C, 1, 0);
    add(1, 4'h0, 4'h0, 3, 8'h3C, 0, 0);
    // src2 granted, then reset at hold_cnt=1
    add(1, 4'h2, 4'h2, 1, 8'h3C, 0, 0);
    add(1, 4'h4, 4'h4, 2, 8'h21, 1, 2);
    add(1, 4'h4, 4'h4, 2, 8'hA5, 1, 2);
    add(0, 4'h6, 4'h0, 0, 8'h00, 0, 0);
    add(1, 4'h6, 4'h2, 1, 8'h00, 0, 0);
    add(1, 4'h6, 4'h2, 1, 8'h21, 1, -1);
    add(1, 4'h0, 4'h0, 1, 8'h21, 1, 2);
    add(1, 4'h0, 4'h0, 1, 8'h21, 0, 2);

    foreach (vecs[i]) begin
      @(posedge clk);
      #2;
      rst_n   = vecs[i].rst_n;
      bus.req = vecs[i].req;
      exp_q.push_back(vecs[i]);
    end
    repeat (2) @(posedge clk);
    #3;
    check("drain", mon_idx, 32'(exp_q.size()), 32'd0);
    check("vec_count", mon_idx, 32'(mon_idx), 32'(vecs.size()));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
